i2c_fnv_target: RTL and testbench
=================================

I2C_FNV_TARGET -- requirements
Module: i2c_fnv_target

Interface
REQ-001 Parameter HASH_WIDTH, default 32, FNV-1a width; legal values 32 and 64 only.
REQ-002 Parameter TARGET_ADDR, default 7'h2A, 7-bit I2C target address.
REQ-003 Parameter SYNC_STAGES, default 2, synchroniser depth on sck/read_channel; minimum 2.
REQ-004 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sck  input  1  I2C SCL, asynchronous to clk.
REQ-007 read_channel  input  1  I2C SDA line as sampled from the pad, asynchronous.
REQ-008 write_channel  output  1  SDA drive value; SHALL be constant 0 (open-drain).
REQ-009 direction  output  1  1 = pull SDA low, 0 = release SDA.
REQ-010 hash_out  output  HASH_WIDTH  current FNV-1a state.
REQ-011 byte_count  output  16  bytes hashed since last clear; saturates at 16'hFFFF.
REQ-012 busy  output  1  high from an addressed START until the following STOP.

Function
REQ-013 sck and read_channel SHALL each pass through SYNC_STAGES flops; all edge, START and STOP detection SHALL use the synchronised values only.
REQ-014 START = synchronised SDA falling while SCL high; STOP = SDA rising while SCL high; both recognised in every state, with STOP → IDLE and START → ADDR (repeated START supported).
REQ-015 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-016 Incoming bits SHALL be sampled on SCL rising edge, MSB first; direction SHALL change only on a detected SCL falling edge.
REQ-017 ADDR: after 8 bits, address match → ADDR_ACK (direction=1 for one SCL high period); mismatch → IGNORE with direction=0 until the next START/STOP.
REQ-018 R/W=0 → WR_DATA; each completed byte b SHALL update hash ← (hash XOR b) × PRIME mod 2^HASH_WIDTH one clk after the 8th rising edge, increment byte_count, then ACK in WR_ACK.
REQ-019 PRIME = 32'h01000193 (32-bit) or 64'h00000100000001B3 (64-bit); OFFSET = 32'h811C9DC5 or 64'hCBF29CE484222325.
REQ-020 A write transaction that ends in STOP or repeated START with zero data bytes after an ACKed address SHALL clear the hash to OFFSET and byte_count to 0 one clk after detection.
REQ-021 R/W=1 → RD_DATA: target shifts out hash bytes MSB byte first, bit value 0 → direction=1, bit value 1 → direction=0.
REQ-022 Read byte index SHALL start at 0 at each START and wrap from HASH_WIDTH/8−1 to 0.
REQ-023 RD_ACK: direction=0; master ACK → next byte; master NACK → IGNORE.
REQ-024 The hash SHALL not change during a read (no write path is active).
REQ-025 busy SHALL be 0 in IDLE and IGNORE.

Reset
REQ-026 While reset=1: state IDLE, hash_out=OFFSET, byte_count=0, busy=0, direction=0, write_channel=0, synchronisers loaded with 1 (idle bus).
REQ-027 Reset asserted mid-transaction SHALL abort it immediately; after deassertion the block SHALL ignore the bus until the next START.

Verification
REQ-028 After reset (HASH_WIDTH=32) → hash_out=32'h811C9DC5, byte_count=0, direction=0.
REQ-029 START, 0x54 (addr 0x2A, W), 0x61, STOP → address and data ACKed; hash_out=32'hE40C292C, byte_count=1.
REQ-030 HASH_WIDTH=64, same write of 0x61 → hash_out=64'hAF63DC4C8601EC8C.
REQ-031 After REQ-029, START, 0x55, read 5 bytes with ACK except NACK on the last, STOP → bytes E4,0C,29,2C,E4 (wrap); busy falls at STOP.
REQ-032 START, 0x56 (addr 0x2B) → no ACK (direction stays 0), subsequent bytes ignored, hash unchanged; then START, 0x54, STOP → hash_out=OFFSET, byte_count=0.
REQ-033 reset pulsed during the 4th bit of a data byte → outputs at REQ-026 values; next full write of 0x61 yields 32'hE40C292C.

Source files
------------

// File: rtl/i2c_fnv_target_if.sv
// I2C pad-side bundle for the FNV-1a hashing target.
//   sck           : SCL as seen at the pad (asynchronous to clk)
//   read_channel  : SDA as sampled from the pad (asynchronous to clk)
//   write_channel : SDA drive value, always 0 (open-drain output)
//   direction     : 1 = pull SDA low, 0 = release SDA
// The master modport is the bus/pad side; the slave modport is the target.
interface i2c_fnv_target_if;
  logic sck;
  logic read_channel;
  logic write_channel;
  logic direction;

  modport master (
    output sck,
    output read_channel,
    input  write_channel,
    input  direction
  );

  modport slave (
    input  sck,
    input  read_channel,
    output write_channel,
    output direction
  );
endinterface

// File: rtl/i2c_fnv_target.sv
// I2C write/read target that folds every received data byte into an FNV-1a
// hash and lets the master read the hash back, MSB byte first.
//   clk        : single clock, all state updates on its rising edge
//   reset      : synchronous, active-high
//   bus        : I2C pad signals (slave modport of i2c_fnv_target_if)
//   hash_out   : current FNV-1a state
//   byte_count : bytes hashed since last clear, saturating at 16'hFFFF
//   busy       : transaction in progress (0 in IDLE and IGNORE)
// A write transaction with an ACKed address but no data bytes clears the
// hash back to the FNV offset basis and zeroes byte_count.
module i2c_fnv_target #(
  parameter int         HASH_WIDTH  = 32,
  parameter logic [6:0] TARGET_ADDR = 7'h2A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  i2c_fnv_target_if.slave       bus,
  output logic [HASH_WIDTH-1:0] hash_out,
  output logic [15:0]           byte_count,
  output logic                  busy
);

  if (!(HASH_WIDTH == 32 || HASH_WIDTH == 64)) begin : g_bad_width
    $error("i2c_fnv_target: HASH_WIDTH must be 32 or 64");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("i2c_fnv_target: SYNC_STAGES must be at least 2");
  end

  localparam logic [HASH_WIDTH-1:0] PRIME = HASH_WIDTH'((HASH_WIDTH == 64) ?
      64'h00000100000001B3 : 64'h0000000001000193);
  localparam logic [HASH_WIDTH-1:0] OFFSET = HASH_WIDTH'((HASH_WIDTH == 64) ?
      64'hCBF29CE484222325 : 64'h00000000811C9DC5);
  localparam logic [2:0] LAST_IDX   = 3'(HASH_WIDTH / 8 - 1);
  // Synchroniser plus the previous-value flop must hold real bus samples
  // before edges are trusted.
  localparam logic [7:0] SETTLE_CYC = 8'(SYNC_STAGES + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_e;

  function automatic logic [HASH_WIDTH-1:0] fnv_step(
    input logic [HASH_WIDTH-1:0] h, input logic [7:0] b);
    logic [HASH_WIDTH-1:0] x;
    x = h ^ {{(HASH_WIDTH-8){1'b0}}, b};
    return x * PRIME;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Byte idx of the hash, counting from the most significant byte.
  function automatic logic [7:0] byte_sel(
    input logic [HASH_WIDTH-1:0] h, input logic [2:0] idx);
    logic [HASH_WIDTH-1:0] s;
    s = h << {idx, 3'b000};
    return s[HASH_WIDTH-1 -: 8];
  endfunction

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0]  sda_sync_q, sda_sync_d;
  logic                    scl_prev_q, scl_prev_d;
  logic                    sda_prev_q, sda_prev_d;
  logic [7:0]              settle_q, settle_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [7:0]              shift_q, shift_d;
  logic [2:0]              rd_idx_q, rd_idx_d;
  logic                    ack_q, ack_d;
  logic                    dir_q, dir_d;
  logic [HASH_WIDTH-1:0]   hash_q, hash_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    wr_empty_q, wr_empty_d;

  logic       scl_s, sda_s, settled;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte, cur_byte;
  logic [2:0] tx_idx;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign settled   = (settle_q == SETTLE_CYC);
  assign scl_rise  = settled &  scl_s & ~scl_prev_q;
  assign scl_fall  = settled & ~scl_s &  scl_prev_q;
  assign start_det = settled & scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
  assign stop_det  = settled & scl_s & scl_prev_q & ~sda_prev_q &  sda_s;
  assign rx_byte   = {shift_q[6:0], sda_s};
  assign cur_byte  = byte_sel(hash_q, rd_idx_q);
  assign tx_idx    = 3'd7 - bit_cnt_q[2:0];

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], bus.sck};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], bus.read_channel};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    settle_d   = settled ? settle_q : settle_q + 8'd1;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rd_idx_d   = rd_idx_q;
    ack_d      = ack_q;
    dir_d      = dir_q;
    hash_d     = hash_q;
    cnt_d      = cnt_q;
    wr_empty_d = wr_empty_q;

    if (start_det || stop_det) begin
      state_d    = start_det ? ADDR : IDLE;
      bit_cnt_d  = 4'd0;
      rd_idx_d   = 3'd0;
      dir_d      = 1'b0;
      wr_empty_d = 1'b0;
      if (wr_empty_q) begin
        hash_d = OFFSET;
        cnt_d  = 16'd0;
      end
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shift_q[7:1] == TARGET_ADDR) begin
              state_d    = ADDR_ACK;
              dir_d      = 1'b1;
              wr_empty_d = ~shift_q[0];
            end else begin
              state_d = IGNORE;
              dir_d   = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          // End of the ACK clock: a read puts its first bit on the bus now.
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (shift_q[0]) begin
              state_d = RD_DATA;
              dir_d   = ~cur_byte[7];
            end else begin
              state_d = WR_DATA;
              dir_d   = 1'b0;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              hash_d     = fnv_step(hash_q, rx_byte);
              cnt_d      = sat_inc(cnt_q);
              wr_empty_d = 1'b0;
            end
          end
          if (scl_fall && bit_cnt_q == 4'd8) begin
            state_d = WR_ACK;
            dir_d   = 1'b1;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_d   = WR_DATA;
            dir_d     = 1'b0;
            bit_cnt_d = 4'd0;
          end
        end
        RD_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) bit_cnt_d = bit_cnt_q + 4'd1;
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d  = RD_ACK;
              dir_d    = 1'b0;
              rd_idx_d = (rd_idx_q == LAST_IDX) ? 3'd0 : rd_idx_q + 3'd1;
            end else begin
              dir_d = ~cur_byte[tx_idx];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) ack_d = sda_s;
          if (scl_fall) begin
            if (!ack_q) begin
              state_d   = RD_DATA;
              bit_cnt_d = 4'd0;
              dir_d     = ~cur_byte[7];
            end else begin
              state_d = IGNORE;
              dir_d   = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      settle_q   <= 8'd0;
      bit_cnt_q  <= 4'd0;
      rd_idx_q   <= 3'd0;
      ack_q      <= 1'b1;
      dir_q      <= 1'b0;
      hash_q     <= OFFSET;
      cnt_q      <= 16'd0;
      wr_empty_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      settle_q   <= settle_d;
      bit_cnt_q  <= bit_cnt_d;
      rd_idx_q   <= rd_idx_d;
      ack_q      <= ack_d;
      dir_q      <= dir_d;
      hash_q     <= hash_d;
      cnt_q      <= cnt_d;
      wr_empty_q <= wr_empty_d;
    end
  end

  // Shift register carries data only; its contents are qualified by bit_cnt.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign bus.write_channel = 1'b0;
  assign bus.direction     = dir_q;
  assign hash_out          = hash_q;
  assign byte_count        = cnt_q;
  assign busy              = (state_q != IDLE) && (state_q != IGNORE);

endmodule

// File: tb/tb_i2c_fnv_target.sv
// Directed bench for i2c_fnv_target: a 32-bit and a 64-bit instance share the
// same bit-banged master; each sees its own wired-AND SDA line.
module tb_i2c_fnv_target;

  localparam int Q = 6;   // clocks between SCL edges and SDA changes
  localparam int H = 12;  // clocks SCL is held high per bit

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl = 1'b1;
  logic sda_m = 1'b1;

  logic [31:0] hash32;
  logic [63:0] hash64;
  logic [15:0] cnt32, cnt64;
  logic        busy32, busy64;

  i2c_fnv_target_if bus32();
  i2c_fnv_target_if bus64();

  assign bus32.sck          = scl;
  assign bus64.sck          = scl;
  assign bus32.read_channel = sda_m & ~bus32.direction;
  assign bus64.read_channel = sda_m & ~bus64.direction;

  i2c_fnv_target #(.HASH_WIDTH(32), .TARGET_ADDR(7'h2A), .SYNC_STAGES(2)) dut32 (
    .clk(clk), .reset(reset), .bus(bus32),
    .hash_out(hash32), .byte_count(cnt32), .busy(busy32));

  i2c_fnv_target #(.HASH_WIDTH(64), .TARGET_ADDR(7'h2A), .SYNC_STAGES(2)) dut64 (
    .clk(clk), .reset(reset), .bus(bus64),
    .hash_out(hash64), .byte_count(cnt64), .busy(busy64));

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  typedef enum logic [2:0] {
    OP_START, OP_STOP, OP_WR, OP_RD, OP_CHK_HASH, OP_CHK_CNT, OP_CHK_BUSY, OP_CHK_H64
  } op_e;

  // din: byte to write (OP_WR) or bit the master sends after a read byte (OP_RD, 1 = NACK)
  // exp: 1 = ACK expected (OP_WR), byte expected (OP_RD), value expected (checks)
  typedef struct {
    op_e         op;
    logic [7:0]  din;
    logic [63:0] exp;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clks(Q);
    scl   = 1'b1; wait_clks(Q);
    sda_m = 1'b0; wait_clks(Q);
    scl   = 1'b0; wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clks(Q);
    scl   = 1'b1; wait_clks(Q);
    sda_m = 1'b1; wait_clks(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clks(Q);
    scl   = 1'b1; wait_clks(H);
    scl   = 1'b0; wait_clks(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clks(Q);
    scl   = 1'b1; wait_clks(H / 2);
    b = bus32.read_channel;
    wait_clks(H / 2);
    scl   = 1'b0; wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ackv;
    logic [7:0] rb;

    vecs[0]  = '{OP_START,    8'h00, 64'h0};
    vecs[1]  = '{OP_WR,       8'h54, 64'h1};
    vecs[2]  = '{OP_CHK_BUSY, 8'h00, 64'h1};
    vecs[3]  = '{OP_WR,       8'h61, 64'h1};
    vecs[4]  = '{OP_STOP,     8'h00, 64'h0};
    vecs[5]  = '{OP_CHK_HASH, 8'h00, 64'hE40C292C};
    vecs[6]  = '{OP_CHK_CNT,  8'h00, 64'h1};
    vecs[7]  = '{OP_CHK_BUSY, 8'h00, 64'h0};
    vecs[8]  = '{OP_CHK_H64,  8'h00, 64'hAF63DC4C8601EC8C};
    vecs[9]  = '{OP_START,    8'h00, 64'h0};
    vecs[10] = '{OP_WR,       8'h55, 64'h1};
    vecs[11] = '{OP_RD,       8'h00, 64'hE4};
    vecs[12] = '{OP_RD,       8'h00, 64'h0C};
    vecs[13] = '{OP_RD,       8'h00, 64'h29};
    vecs[14] = '{OP_CHK_BUSY, 8'h00, 64'h1};
    vecs[15] = '{OP_RD,       8'h00, 64'h2C};
    vecs[16] = '{OP_RD,       8'h01, 64'hE4};
    vecs[17] = '{OP_STOP,     8'h00, 64'h0};
    vecs[18] = '{OP_CHK_BUSY, 8'h00, 64'h0};
    vecs[19] = '{OP_CHK_HASH, 8'h00, 64'hE40C292C};
    vecs[20] = '{OP_CHK_CNT,  8'h00, 64'h1};
    vecs[21] = '{OP_START,    8'h00, 64'h0};
    vecs[22] = '{OP_WR,       8'h56, 64'h0};
    vecs[23] = '{OP_CHK_BUSY, 8'h00, 64'h0};
    vecs[24] = '{OP_WR,       8'h61, 64'h0};
    vecs[25] = '{OP_CHK_HASH, 8'h00, 64'hE40C292C};
    vecs[26] = '{OP_START,    8'h00, 64'h0};
    vecs[27] = '{OP_WR,       8'h54, 64'h1};
    vecs[28] = '{OP_STOP,     8'h00, 64'h0};
    vecs[29] = '{OP_CHK_HASH, 8'h00, 64'h811C9DC5};
    vecs[30] = '{OP_CHK_CNT,  8'h00, 64'h0};

    // Reset state
    reset = 1'b1;
    wait_clks(5);
    reset = 1'b0;
    wait_clks(5);
    chk("rst hash32", 64'(hash32), 64'h811C9DC5);
    chk("rst hash64", hash64, 64'hCBF29CE484222325);
    chk("rst count", 64'(cnt32), 64'h0);
    chk("rst direction", 64'(bus32.direction), 64'h0);
    chk("rst busy", 64'(busy32), 64'h0);
    chk("rst write_channel", 64'(bus32.write_channel), 64'h0);

    for (int i = 0; i < NV; i++) begin
      case (vecs[i].op)
        OP_START: i2c_start();
        OP_STOP:  i2c_stop();
        OP_WR: begin
          write_byte(vecs[i].din, ackv);
          chk($sformatf("v%0d write ack", i), 64'(ackv), vecs[i].exp);
        end
        OP_RD: begin
          read_byte(vecs[i].din[0], rb);
          chk($sformatf("v%0d read byte", i), 64'(rb), vecs[i].exp);
        end
        OP_CHK_HASH: chk($sformatf("v%0d hash32", i), 64'(hash32), vecs[i].exp);
        OP_CHK_CNT:  chk($sformatf("v%0d count", i), 64'(cnt32), vecs[i].exp);
        OP_CHK_BUSY: chk($sformatf("v%0d busy", i), 64'(busy32), vecs[i].exp);
        OP_CHK_H64:  chk($sformatf("v%0d hash64", i), hash64, vecs[i].exp);
        default: ;
      endcase
    end

    // Reload a known hash before the abort sequence
    i2c_start();
    write_byte(8'h54, ackv);
    write_byte(8'h61, ackv);
    i2c_stop();
    chk("pre-abort hash32", 64'(hash32), 64'hE40C292C);

    // Reset pulsed while SCL is high during the 4th bit of a data byte
    i2c_start();
    write_byte(8'h54, ackv);
    chk("abort addr ack", 64'(ackv), 64'h1);
    write_bit(1'b0);
    write_bit(1'b1);
    write_bit(1'b1);
    sda_m = 1'b0; wait_clks(Q);
    scl   = 1'b1; wait_clks(4);
    reset = 1'b1; wait_clks(2);
    chk("abort hash32", 64'(hash32), 64'h811C9DC5);
    chk("abort count", 64'(cnt32), 64'h0);
    chk("abort direction", 64'(bus32.direction), 64'h0);
    chk("abort busy", 64'(busy32), 64'h0);
    chk("abort write_channel", 64'(bus32.write_channel), 64'h0);
    reset = 1'b0; wait_clks(H);
    scl   = 1'b0; wait_clks(Q);
    write_bit(1'b0);
    write_bit(1'b0);
    write_bit(1'b0);
    write_bit(1'b1);
    read_bit(rb[0]);
    chk("post-abort no ack", 64'(rb[0]), 64'h1);
    chk("post-abort busy", 64'(busy32), 64'h0);
    chk("post-abort count", 64'(cnt32), 64'h0);
    i2c_stop();

    i2c_start();
    write_byte(8'h54, ackv);
    write_byte(8'h61, ackv);
    chk("rewrite data ack", 64'(ackv), 64'h1);
    i2c_stop();
    chk("rewrite hash32", 64'(hash32), 64'hE40C292C);
    chk("rewrite count", 64'(cnt32), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
